// File: rtl/rotation_pkg.sv
// Shared types, trig-table geometry and the quarter-wave sine generator for the rotation sequencer.
package rotation_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int unsigned QUAD_W       = 2;
  localparam int unsigned ADDR_W       = 6;
  localparam int unsigned TRIG_PHASE_W = QUAD_W + ADDR_W;
  localparam int unsigned LUT_LAST     = 1 << ADDR_W;

  localparam logic [QUAD_W-1:0] QUAD_0 = 2'd0;
  localparam logic [QUAD_W-1:0] QUAD_1 = 2'd1;
  localparam logic [QUAD_W-1:0] QUAD_2 = 2'd2;
  localparam logic [QUAD_W-1:0] QUAD_3 = 2'd3;

  // round(2^nbf * sin(2*pi*k/256)) via a Q30 Taylor series; valid for k in 0..64, nbf <= 29.
  function automatic longint q_entry(input int unsigned k, input int unsigned nbf);
    longint x;
    longint x2;
    longint term;
    longint acc;
    x    = (longint'(k) * 64'sd2635358931) / 64'sd100;
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int unsigned n = 1; n < 12; n++) begin
      term = (term * x2) >>> 30;
      term = -(term / longint'((2 * n) * (2 * n + 1)));
      acc  = acc + term;
    end
    return (acc + (longint'(1) <<< (29 - nbf))) >>> (30 - nbf);
  endfunction

endpackage

// File: rtl/sincos_lut.sv
// Registered quarter-wave sin/cos lookup; forms the second pipeline stage.
module sincos_lut
  import rotation_pkg::*;
#(
  parameter int unsigned NB_OUTPUT  = 8,
  parameter int unsigned NBF_OUTPUT = 6
) (
  input  logic                          clock,
  input  logic                          i_reset,
  input  logic                          i_load,
  input  logic [TRIG_PHASE_W-1:0]       i_phase,
  output logic signed [NB_OUTPUT-1:0]   o_sin,
  output logic signed [NB_OUTPUT-1:0]   o_cos
);

  logic [NB_OUTPUT-1:0] q_tab [LUT_LAST+1];

  for (genvar k = 0; k <= LUT_LAST; k++) begin : g_tab
    localparam logic [NB_OUTPUT-1:0] QV = NB_OUTPUT'(q_entry(k, NBF_OUTPUT));
    assign q_tab[k] = QV;
  end

  logic [QUAD_W-1:0]    quad;
  logic [ADDR_W:0]      addr;
  logic [NB_OUTPUT-1:0] mag_a;
  logic [NB_OUTPUT-1:0] mag_c;
  logic [NB_OUTPUT-1:0] sin_d;
  logic [NB_OUTPUT-1:0] cos_d;
  logic [NB_OUTPUT-1:0] sin_q;
  logic [NB_OUTPUT-1:0] cos_q;

  always_comb begin
    quad  = i_phase[TRIG_PHASE_W-1 -: QUAD_W];
    addr  = {1'b0, i_phase[ADDR_W-1:0]};
    mag_a = q_tab[addr];
    mag_c = q_tab[(ADDR_W+1)'(LUT_LAST) - addr];
    sin_d = '0;
    cos_d = '0;
    unique case (quad)
      QUAD_0: begin
        sin_d = mag_a;
        cos_d = mag_c;
      end
      QUAD_1: begin
        sin_d = mag_c;
        cos_d = '0 - mag_a;
      end
      QUAD_2: begin
        sin_d = '0 - mag_a;
        cos_d = '0 - mag_c;
      end
      QUAD_3: begin
        sin_d = '0 - mag_c;
        cos_d = mag_a;
      end
      default: begin
        sin_d = '0;
        cos_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      sin_q <= '0;
      cos_q <= '0;
    end else if (i_load) begin
      sin_q <= sin_d;
      cos_q <= cos_d;
    end
  end

  always_comb begin
    o_sin = sin_q;
    o_cos = cos_q;
  end

endmodule

// File: rtl/rotation_sequencer.sv
// Phase accumulator, config FSM and I/Q alignment pipeline feeding the combinational rotator.
module rotation_sequencer
  import rotation_pkg::*;
#(
  parameter int unsigned NB_OUTPUT  = 8,
  parameter int unsigned NBF_OUTPUT = 6,
  parameter int unsigned NB_PHASE   = 10
) (
  input  logic                        clock,
  input  logic                        i_reset,
  input  logic                        i_enable,
  input  logic                        i_cfg_valid,
  input  logic [NB_PHASE-1:0]         i_cfg_phase_inc,
  input  logic [NB_PHASE-1:0]         i_cfg_phase_init,
  output logic                        o_cfg_ready,
  input  logic                        i_valid,
  input  logic signed [NB_OUTPUT-1:0] i_dataI,
  input  logic signed [NB_OUTPUT-1:0] i_dataQ,
  output logic                        o_ready,
  output logic                        o_valid,
  output logic signed [NB_OUTPUT-1:0] o_dataI,
  output logic signed [NB_OUTPUT-1:0] o_dataQ,
  output logic signed [NB_OUTPUT-1:0] o_dataSin,
  output logic signed [NB_OUTPUT-1:0] o_dataCos,
  output logic [NB_PHASE-1:0]         o_phase
);

  state_t                  state_q, state_d;
  logic [NB_PHASE-1:0]     phase_q, phase_d;
  logic [NB_PHASE-1:0]     inc_q, inc_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s2_valid_q, s2_valid_d;
  logic [NB_OUTPUT-1:0]    s1_i_q, s1_i_d;
  logic [NB_OUTPUT-1:0]    s1_q_q, s1_q_d;
  logic [TRIG_PHASE_W-1:0] s1_ph_q, s1_ph_d;
  logic [NB_OUTPUT-1:0]    s2_i_q, s2_i_d;
  logic [NB_OUTPUT-1:0]    s2_q_q, s2_q_d;
  logic                    pipe_empty;
  logic                    accept;
  logic                    cfg_fire;
  logic signed [NB_OUTPUT-1:0] lut_sin;
  logic signed [NB_OUTPUT-1:0] lut_cos;

  always_comb begin
    pipe_empty  = !s1_valid_q && !s2_valid_q;
    o_ready     = (state_q == ST_RUN) && i_enable;
    o_cfg_ready = (state_q != ST_RUN) && pipe_empty;
    accept      = i_valid && o_ready;
    cfg_fire    = i_cfg_valid && o_cfg_ready;
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    inc_d      = inc_q;
    s1_valid_d = accept;
    s2_valid_d = s1_valid_q;
    s1_i_d     = s1_i_q;
    s1_q_d     = s1_q_q;
    s1_ph_d    = s1_ph_q;
    s2_i_d     = s2_i_q;
    s2_q_d     = s2_q_q;

    if (accept) begin
      s1_i_d  = i_dataI;
      s1_q_d  = i_dataQ;
      s1_ph_d = phase_q[NB_PHASE-1 -: TRIG_PHASE_W];
      phase_d = phase_q + inc_q;
    end
    if (s1_valid_q) begin
      s2_i_d = s1_i_q;
      s2_q_d = s1_q_q;
    end

    // A request seen in RUN still lets that cycle's sample through with the old config.
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_fire) begin
          phase_d = i_cfg_phase_init;
          inc_d   = i_cfg_phase_inc;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (i_cfg_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (cfg_fire) begin
          phase_d = i_cfg_phase_init;
          inc_d   = i_cfg_phase_inc;
          state_d = ST_RUN;
        end else if (!i_cfg_valid) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      phase_q    <= '0;
      inc_q      <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_i_q     <= '0;
      s1_q_q     <= '0;
      s1_ph_q    <= '0;
      s2_i_q     <= '0;
      s2_q_q     <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      inc_q      <= inc_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_i_q     <= s1_i_d;
      s1_q_q     <= s1_q_d;
      s1_ph_q    <= s1_ph_d;
      s2_i_q     <= s2_i_d;
      s2_q_q     <= s2_q_d;
    end
  end

  sincos_lut #(
    .NB_OUTPUT  (NB_OUTPUT),
    .NBF_OUTPUT (NBF_OUTPUT)
  ) u_sincos_lut (
    .clock   (clock),
    .i_reset (i_reset),
    .i_load  (s1_valid_q),
    .i_phase (s1_ph_q),
    .o_sin   (lut_sin),
    .o_cos   (lut_cos)
  );

  always_comb begin
    o_valid   = s2_valid_q;
    o_dataI   = s2_i_q;
    o_dataQ   = s2_q_q;
    o_dataSin = lut_sin;
    o_dataCos = lut_cos;
    o_phase   = phase_q;
  end

endmodule

// File: doc/rotation_sequencer.md
# rotation_sequencer

Sequencer for the I/Q phase-rotation datapath. It owns a phase accumulator and a quarter-wave sin/cos table. For each accepted I/Q sample it delivers a time-aligned {I, Q, sin, cos} set to the combinational rotator, and it applies new phase-increment configurations without corrupting samples in flight.

## Interface
- NB_OUTPUT, 8, total data/trig width, S(NB_OUTPUT,NBF_OUTPUT); must be ≥ NBF_OUTPUT+2
- NBF_OUTPUT, 6, fractional bits of data and trig values
- NB_PHASE, 10, phase accumulator width (unsigned, full turn = 2^NB_PHASE); must be ≥ 8
- clock  in  1  single clock; all logic rising-edge
- i_reset  in  1  synchronous, active-high reset
- i_enable  in  1  soft run gate; low blocks new sample acceptance
- i_cfg_valid  in  1  configuration request; held until accepted
- i_cfg_phase_inc  in  NB_PHASE  phase step per sample
- i_cfg_phase_init  in  NB_PHASE  starting phase
- o_cfg_ready  out  1  configuration accepted when high with i_cfg_valid
- i_valid  in  1  input sample valid
- i_dataI, i_dataQ  in  NB_OUTPUT  input sample
- o_ready  out  1  sample accepted when high with i_valid
- o_valid  out  1  aligned set valid
- o_dataI, o_dataQ, o_dataSin, o_dataCos  out  NB_OUTPUT  to rotator inputs
- o_phase  out  NB_PHASE  phase that the next accepted sample will use

## Operation
- States: IDLE (reset state, no configuration), RUN, DRAIN.
- IDLE: o_ready=0. i_cfg_valid&o_cfg_ready loads inc and phase, then goes to RUN.
- RUN: o_ready=i_enable. Each accepted sample latches the current phase, then phase += inc mod 2^NB_PHASE.
  - i_cfg_valid high goes to DRAIN on the next cycle.
  - A sample accepted in the same cycle as the request is processed with the old configuration.
- DRAIN: o_ready=0. o_cfg_ready=1 only once both pipeline stages are empty. The handshake loads the new config and returns to RUN.
  - If i_cfg_valid drops before acceptance, return to RUN with the config unchanged.
- o_cfg_ready = (state≠RUN) & pipeline empty.
- Phase to trig conversion:
  - quad = phase[NB_PHASE-1 -: 2]; a = phase[NB_PHASE-3 -: 6]. Lower bits are truncated.
  - q[k] = round(2^NBF_OUTPUT·sin(2πk/256)), k=0..64. q[0]=0, q[32]=45, q[64]=64.
  - sin: quad0 q[a], quad1 q[64-a], quad2 −q[a], quad3 −q[64-a].
  - cos: quad0 q[64-a], quad1 −q[a], quad2 −q[64-a], quad3 q[a].
- I/Q pass through unmodified. No downstream backpressure, because the rotator is combinational.

## Timing
- Reset: state=IDLE, phase=0, inc=0, both pipeline valids cleared. All data outputs 0, o_valid=0, o_ready=0, o_cfg_ready=1 in the cycle after reset.
- Reset asserted mid-operation discards the in-flight samples within one cycle.
- Latency: a sample accepted at edge t appears with o_valid=1 after edge t+2. Throughput is one sample per cycle.
  - Stage 1 registers I/Q and the LUT address/quadrant.
  - Stage 2 registers the LUT output and the delayed I/Q.
- Sample n after a config uses phase init + n·inc.
- Config-to-first-accept:
  - From IDLE: accept at t, o_ready high at t+1.
  - From RUN: at most 4 cycles from i_cfg_valid rising to o_cfg_ready.
- i_enable low: no accepts. Pipeline keeps draining and phase holds.
- Phase wraps silently at 2^NB_PHASE.

## Structure
- Package rotation_pkg holds:
  - state enum
  - quadrant/address localparams
  - q[0..64] constant table generated from NBF_OUTPUT
- Sub-module sincos_lut: registered, 1-cycle; phase in, sin/cos out; forms stage 2.
- The top level holds the FSM, the accumulator and the I/Q delay registers.

## Test plan
- Reset, then config init=0, inc=256; stream 5 samples → sin 0,64,0,−64,0 and cos 64,0,−64,0,64, each o_valid 2 cycles after accept.
- init=128, inc=0 → every output sin=45, cos=45; I/Q echoed unchanged (e.g. I=37, Q=−20).
- init=1000, inc=40 → phases 1000, 16, 56: wrap correct, o_phase matches.
- Config request during a continuous stream → no sample dropped or duplicated; the samples before the switch use the old inc and all later samples use the new inc; o_cfg_ready only asserts once the pipeline is empty.
- i_reset pulsed with 2 samples in flight → o_valid stays 0 afterward, outputs 0, state IDLE, o_ready 0 until reconfigured.
- i_enable low for 3 cycles mid-stream with i_valid high → o_ready 0, phase frozen, resumes with the correct next phase.
